// File: rtl/mem_arbiter_if.sv
// Request/response bus between a requester and a memory-side responder.
// The requester drives valid and the request fields, and the responder answers
// with a one-cycle ready pulse that carries rdata for reads.
interface mem_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid,
        output instr,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  instr,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single shared memory port.
// Master 0 is the CPU and master 1 is the DMA. One transaction is in flight at
// a time. The request fields are registered toward memory, and the completion
// (or a forced completion after TIMEOUT wait cycles) is returned to the owner
// combinationally in the cycle the memory answers.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] RESP_ERR = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic          grant,
    output logic          timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

    state_t      state;
    state_t      state_next;
    logic        grant_next;
    logic        take;
    logic        done;
    logic        timed_out;
    logic        complete;
    logic [15:0] wait_cnt;
    logic [31:0] resp_data;

    logic        s_valid_q;
    logic        s_instr_q;
    logic [31:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic [3:0]  s_wstrb_q;

    logic        win_instr;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_wstrb;

    // Decide who wins in IDLE, and whether the outstanding transaction ends this cycle in BUSY
    always_comb begin
        state_next = state;
        grant_next = grant;
        take       = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (m0.valid && m1.valid) begin
                    take       = 1'b1;
                    grant_next = ~grant;
                end else if (m0.valid) begin
                    take       = 1'b1;
                    grant_next = 1'b0;
                end else if (m1.valid) begin
                    take       = 1'b1;
                    grant_next = 1'b1;
                end
                if (take) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (s.ready) begin
                    done = 1'b1;
                end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_CNT)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Select the winning master's request fields so they can be latched on grant
    always_comb begin
        win_instr = m0.instr;
        win_addr  = m0.addr;
        win_wdata = m0.wdata;
        win_wstrb = m0.wstrb;
        if (grant_next) begin
            win_instr = m1.instr;
            win_addr  = m1.addr;
            win_wdata = m1.wdata;
            win_wstrb = m1.wstrb;
        end
    end

    // State, request registers, owner index and wait counter; reset abandons any transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s_valid_q <= 1'b0;
            s_instr_q <= 1'b0;
            s_addr_q  <= 32'd0;
            s_wdata_q <= 32'd0;
            s_wstrb_q <= 4'd0;
            grant     <= 1'b1;
            wait_cnt  <= 16'd0;
        end else begin
            state <= state_next;
            if (take) begin
                s_valid_q <= 1'b1;
                s_instr_q <= win_instr;
                s_addr_q  <= win_addr;
                s_wdata_q <= win_wdata;
                s_wstrb_q <= win_wstrb;
                grant     <= grant_next;
                wait_cnt  <= 16'd0;
            end else if (done) begin
                s_valid_q <= 1'b0;
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    // A completion held under reset is suppressed so an abandoned transaction never acknowledges
    assign complete    = done && !reset;
    assign resp_data   = timed_out ? RESP_ERR : s.rdata;
    assign timeout_err = timed_out && !reset;

    assign m0.ready = complete && (grant == 1'b0);
    assign m0.rdata = (complete && (grant == 1'b0)) ? resp_data : 32'd0;
    assign m1.ready = complete && (grant == 1'b1);
    assign m1.rdata = (complete && (grant == 1'b1)) ? resp_data : 32'd0;

    assign s.valid = s_valid_q;
    assign s.instr = s_instr_q;
    assign s.addr  = s_addr_q;
    assign s.wdata = s_wdata_q;
    assign s.wstrb = s_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A responsive memory model answers after a programmable
// latency, a transaction-level reference model predicts every output on every
// cycle, and the directed tests add literal expectations at key points.
module tb_mem_arbiter;

    localparam int          TO   = 4;
    localparam logic [31:0] ERRV = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    logic grant;
    logic timeout_err;

    mem_arbiter_if m0_bus ();
    mem_arbiter_if m1_bus ();
    mem_arbiter_if s_bus ();

    mem_arbiter #(
        .TIMEOUT  (TO),
        .RESP_ERR (ERRV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory model controls: latency -1 means never answer
    int          slave_lat   = 0;
    logic [31:0] slave_data  = 32'd0;
    bit          force_ready = 1'b0;
    int          slave_age   = 0;

    // reference model: one outstanding transaction at most
    bit          mb_busy  = 1'b0;
    bit          mb_owner = 1'b1;
    int          mb_age   = 0;
    logic        mb_instr = 1'b0;
    logic [31:0] mb_addr  = 32'd0;
    logic [31:0] mb_wdata = 32'd0;
    logic [3:0]  mb_wstrb = 4'd0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic instr,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        if (idx == 0) begin
            m0_bus.valid = valid;
            m0_bus.instr = instr;
            m0_bus.addr  = addr;
            m0_bus.wdata = wdata;
            m0_bus.wstrb = wstrb;
        end else begin
            m1_bus.valid = valid;
            m1_bus.instr = instr;
            m1_bus.addr  = addr;
            m1_bus.wdata = wdata;
            m1_bus.wstrb = wstrb;
        end
    endtask

    task automatic waitForReady(input int idx, input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            seen = (idx == 0) ? m0_bus.ready : m1_bus.ready;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_ready_m%0d: no ready within %0d cycles, expected a pulse", idx, limit);
        end
    endtask

    // memory side: answers in BUSY cycle slave_lat+1 counted from s_valid rising
    initial begin
        s_bus.ready = 1'b0;
        s_bus.rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (s_bus.valid) slave_age = slave_age + 1;
            else             slave_age = 0;
            s_bus.ready = force_ready || (s_bus.valid && slave_lat >= 0 && slave_age == slave_lat + 1);
            s_bus.rdata = slave_data;
        end
    end

    // reference model and per-cycle compare
    initial begin
        bit          exp_done;
        bit          exp_to;
        logic [31:0] exp_data;
        bit          v0;
        bit          v1;
        bit          win;
        @(posedge clk);
        forever begin
            @(negedge clk);
            v0       = m0_bus.valid;
            v1       = m1_bus.valid;
            exp_done = !reset && mb_busy && (s_bus.ready || (TO != 0 && mb_age == TO + 1));
            exp_to   = exp_done && !s_bus.ready;
            exp_data = s_bus.ready ? s_bus.rdata : ERRV;

            checkOutput("s_valid", 32'(s_bus.valid), 32'(mb_busy));
            checkOutput("grant", 32'(grant), 32'(mb_owner));
            if (mb_busy) begin
                checkOutput("s_instr", 32'(s_bus.instr), 32'(mb_instr));
                checkOutput("s_addr", s_bus.addr, mb_addr);
                checkOutput("s_wdata", s_bus.wdata, mb_wdata);
                checkOutput("s_wstrb", 32'(s_bus.wstrb), 32'(mb_wstrb));
            end
            checkOutput("m0_ready", 32'(m0_bus.ready), 32'(exp_done && mb_owner == 1'b0));
            checkOutput("m1_ready", 32'(m1_bus.ready), 32'(exp_done && mb_owner == 1'b1));
            if (mb_owner != 1'b0)  checkOutput("m0_rdata_idle", m0_bus.rdata, 32'd0);
            else if (exp_done)     checkOutput("m0_rdata", m0_bus.rdata, exp_data);
            if (mb_owner != 1'b1)  checkOutput("m1_rdata_idle", m1_bus.rdata, 32'd0);
            else if (exp_done)     checkOutput("m1_rdata", m1_bus.rdata, exp_data);
            checkOutput("timeout_err", 32'(timeout_err), 32'(exp_to));

            if (reset) begin
                mb_busy  = 1'b0;
                mb_owner = 1'b1;
                mb_age   = 0;
                mb_instr = 1'b0;
                mb_addr  = 32'd0;
                mb_wdata = 32'd0;
                mb_wstrb = 4'd0;
            end else if (mb_busy) begin
                if (exp_done) mb_busy = 1'b0;
                else          mb_age  = mb_age + 1;
            end else if (v0 || v1) begin
                win      = (v0 && v1) ? !mb_owner : v1;
                mb_owner = win;
                mb_busy  = 1'b1;
                mb_age   = 1;
                mb_instr = win ? m1_bus.instr : m0_bus.instr;
                mb_addr  = win ? m1_bus.addr  : m0_bus.addr;
                mb_wdata = win ? m1_bus.wdata : m0_bus.wdata;
                mb_wstrb = win ? m1_bus.wstrb : m0_bus.wstrb;
            end
        end
    end

    // directed scenarios with literal expectations
    initial begin
        int n;
        int who;
        reset = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_s_valid", 32'(s_bus.valid), 32'd0);
        checkOutput("rst_s_addr", s_bus.addr, 32'd0);
        checkOutput("rst_s_wdata", s_bus.wdata, 32'd0);
        checkOutput("rst_s_wstrb", 32'(s_bus.wstrb), 32'd0);
        checkOutput("rst_s_instr", 32'(s_bus.instr), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd1);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b0;

        $display("[TB] single read");
        slave_lat  = 1;
        slave_data = 32'h0000_0005;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_03FC, 32'd0, 4'd0);
        @(negedge clk);
        checkOutput("rd_s_valid_before", 32'(s_bus.valid), 32'd0);
        @(negedge clk);
        checkOutput("rd_s_valid_after", 32'(s_bus.valid), 32'd1);
        checkOutput("rd_s_addr", s_bus.addr, 32'h0000_03FC);
        waitForReady(0, 10, n);
        checkOutput("rd_latency", 32'(n), 32'd1);
        checkOutput("rd_rdata", m0_bus.rdata, 32'h0000_0005);
        checkOutput("rd_m1_ready", 32'(m1_bus.ready), 32'd0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        checkOutput("rd_back_idle", 32'(s_bus.valid), 32'd0);

        $display("[TB] round robin after reset");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        slave_lat = 0;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 32'h1111_0000, 4'hF);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            who = -1;
            while (who < 0 && n < 10) begin
                @(negedge clk);
                n++;
                if (m0_bus.ready)      who = 0;
                else if (m1_bus.ready) who = 1;
            end
            checkOutput("rr_order", 32'(who), 32'(k % 2));
            checkOutput("rr_period", 32'(n), 32'd2);
            checkOutput("rr_grant", 32'(grant), 32'(k % 2));
            checkOutput("rr_addr", s_bus.addr, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
        end
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        $display("[TB] write pass-through");
        slave_lat = 3;
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0080, 32'hDEAD_BEEF, 4'b0011);
        waitForReady(1, 20, n);
        checkOutput("wr_latency", 32'(n), 32'd5);
        checkOutput("wr_s_addr", s_bus.addr, 32'h0000_0080);
        checkOutput("wr_s_wdata", s_bus.wdata, 32'hDEAD_BEEF);
        checkOutput("wr_s_wstrb", 32'(s_bus.wstrb), 32'h3);
        checkOutput("wr_grant", 32'(grant), 32'd1);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        $display("[TB] timeout");
        slave_lat = -1;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 4'd0);
        waitForReady(0, 20, n);
        checkOutput("to_latency", 32'(n), 32'd6);
        checkOutput("to_flag", 32'(timeout_err), 32'd1);
        checkOutput("to_rdata", m0_bus.rdata, 32'hFFFF_FFFF);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        checkOutput("to_back_idle", 32'(s_bus.valid), 32'd0);
        checkOutput("to_flag_clear", 32'(timeout_err), 32'd0);

        $display("[TB] ready on the timeout cycle");
        tick();
        slave_lat  = 4;
        slave_data = 32'h1234_5678;
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0044, 32'd0, 4'd0);
        waitForReady(0, 20, n);
        checkOutput("co_latency", 32'(n), 32'd6);
        checkOutput("co_flag", 32'(timeout_err), 32'd0);
        checkOutput("co_rdata", m0_bus.rdata, 32'h1234_5678);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        $display("[TB] memory ready while idle");
        force_ready = 1'b1;
        @(negedge clk);
        checkOutput("idle_m0_ready", 32'(m0_bus.ready), 32'd0);
        checkOutput("idle_m1_ready", 32'(m1_bus.ready), 32'd0);
        checkOutput("idle_s_valid", 32'(s_bus.valid), 32'd0);
        tick();
        force_ready = 1'b0;

        $display("[TB] master drops valid mid-transaction");
        slave_lat  = 3;
        slave_data = 32'h0000_00A5;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0048, 32'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        waitForReady(0, 10, n);
        checkOutput("drop_latency", 32'(n), 32'd3);
        checkOutput("drop_rdata", m0_bus.rdata, 32'h0000_00A5);
        tick();

        $display("[TB] reset in the middle of a transaction");
        slave_lat = -1;
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tick();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mr_m1_ready", 32'(m1_bus.ready), 32'd0);
        checkOutput("mr_m0_ready", 32'(m0_bus.ready), 32'd0);
        tick();
        reset     = 1'b0;
        slave_lat = 0;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0304, 32'd0, 4'd0);
        @(negedge clk);
        checkOutput("mr_s_valid", 32'(s_bus.valid), 32'd0);
        waitForReady(0, 5, n);
        checkOutput("mr_tie_latency", 32'(n), 32'd1);
        checkOutput("mr_tie_grant", 32'(grant), 32'd0);
        checkOutput("mr_tie_m1_ready", 32'(m1_bus.ready), 32'd0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
